// File: rtl/apb_timer.sv
// APB timer: prescaled 32-bit counter with compare match, W1C pending flag and level irq.
// Transfers complete with one wait state; writes commit on the response edge.
module apb_timer #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned PRESC_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  input  logic [3:0]        pstrb_i,
  input  logic [2:0]        pprot_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              irq_o
);

  localparam logic [2:0] IdxCtrl    = 3'd0;
  localparam logic [2:0] IdxPresc   = 3'd1;
  localparam logic [2:0] IdxCount   = 3'd2;
  localparam logic [2:0] IdxCompare = 3'd3;
  localparam logic [2:0] IdxStatus  = 3'd4;

  typedef enum logic {StIdle, StResp} state_e;

  state_e               state_q;
  logic [31:0]          prdata_q;
  logic                 pready_q, pslverr_q;

  logic [2:0]           ctrl_q, ctrl_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PRESC_W-1:0]   pcnt_q, pcnt_d;
  logic [31:0]          count_q, count_d;
  logic [31:0]          compare_q, compare_d;
  logic                 pend_q, pend_d;

  logic                 access, commit, tick, hit, w1c, addr_err;
  logic [2:0]           reg_idx;
  logic [31:0]          rdata;
  logic                 unused_bits;

  function automatic logic [31:0] wmerge(input logic [31:0] old_val, input logic [31:0] wval,
                                         input logic [3:0] strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = wval[b*8 +: 8];
    end
    return r;
  endfunction

  assign unused_bits = ^{pprot_i, paddr_i[1:0], paddr_i[ADDR_W-1:5]};

  assign reg_idx = paddr_i[4:2];
  assign access  = psel_i & penable_i;
  // Write lands only if the master is still holding the access phase in the response cycle.
  assign commit  = (state_q == StResp) & access & pwrite_i;
  assign tick    = ctrl_q[0] & (pcnt_q == presc_q);
  assign hit     = tick & (count_q == compare_q);
  assign w1c     = commit & (reg_idx == IdxStatus) & pstrb_i[0] & pwdata_i[0];

  always_comb begin
    rdata    = '0;
    addr_err = 1'b0;
    unique case (reg_idx)
      IdxCtrl:    rdata = {29'd0, ctrl_q};
      IdxPresc:   rdata = 32'(presc_q);
      IdxCount:   rdata = count_q;
      IdxCompare: rdata = compare_q;
      IdxStatus:  rdata = {31'd0, pend_q};
      default:    addr_err = 1'b1;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    compare_d = compare_q;
    pcnt_d    = '0;
    count_d   = count_q;
    if (ctrl_q[0]) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    if (hit)       count_d = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
    else if (tick) count_d = count_q + 32'd1;
    // Software writes override the timer's own update in the same cycle.
    if (commit) begin
      unique case (reg_idx)
        IdxCtrl:    if (pstrb_i[0]) ctrl_d = pwdata_i[2:0];
        IdxPresc: begin
          presc_d = PRESC_W'(wmerge(32'(presc_q), pwdata_i, pstrb_i));
          pcnt_d  = '0;
        end
        IdxCount:   count_d   = wmerge(count_q, pwdata_i, pstrb_i);
        IdxCompare: compare_d = wmerge(compare_q, pwdata_i, pstrb_i);
        default:    ;
      endcase
    end
    pend_d = hit | (pend_q & ~w1c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (access) begin
            state_q   <= StResp;
            pready_q  <= 1'b1;
            prdata_q  <= rdata;
            pslverr_q <= addr_err;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          pready_q  <= 1'b0;
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
        end
      endcase
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign irq_o     = pend_q & ctrl_q[2];

endmodule
